// File: rtl/dmem_seq_ctrl.sv
// Two-port (CPU / debug) sequencer splitting 1-8 byte accesses into byte beats on a synchronous-read memory.
// Optional DMEM_ALIGN_CHECK_EN: misaligned accesses are rejected with err instead of wrapping.
module dmem_seq_ctrl #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic [63:0]       cpu_addr,
    input  logic [63:0]       cpu_wdata,
    output logic [63:0]       cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [1:0]        dbg_size,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [63:0]       dbg_wdata,
    output logic [63:0]       dbg_rdata,
    output logic              dbg_ack,
    output logic              dbg_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, BEAT, RWAIT, DONE} state_t;

    state_t state, state_nxt;

    logic              grant_dbg;
    logic              prio_dbg;
    logic              lat_we;
    logic [1:0]        lat_size;
    logic [ADDR_W-1:0] lat_base;
    logic [63:0]       lat_wdata;
    logic              lat_err;
    logic [2:0]        beat_cnt;
    logic [2:0]        last_idx;
    logic              rd_pend;
    logic [2:0]        rd_idx;
    logic [63:0]       rd_buf;
    logic [63:0]       rd_merged;

    logic              take_cpu, take_dbg;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [63:0]       sel_wdata;
    logic              sel_misaligned;
    logic              addr_hi_unused;

    assign addr_hi_unused = ^cpu_addr[63:ADDR_W];

    // Round-robin: debug wins a tie only when the previous grant went to the CPU.
    always_comb begin
        take_cpu  = cpu_req && !(dbg_req && prio_dbg);
        take_dbg  = dbg_req && !take_cpu;
        sel_we    = take_dbg ? dbg_we    : cpu_we;
        sel_size  = take_dbg ? dbg_size  : cpu_size;
        sel_addr  = take_dbg ? dbg_addr  : cpu_addr[ADDR_W-1:0];
        sel_wdata = take_dbg ? dbg_wdata : cpu_wdata;
    end

`ifdef DMEM_ALIGN_CHECK_EN
    always_comb begin
        case (sel_size)
            2'd0:    sel_misaligned = 1'b0;
            2'd1:    sel_misaligned = sel_addr[0];
            2'd2:    sel_misaligned = |sel_addr[1:0];
            default: sel_misaligned = |sel_addr[2:0];
        endcase
    end
`else
    assign sel_misaligned = 1'b0;
`endif

    always_comb begin
        case (lat_size)
            2'd0:    last_idx = 3'd0;
            2'd1:    last_idx = 3'd1;
            2'd2:    last_idx = 3'd3;
            default: last_idx = 3'd7;
        endcase
    end

    // Load byte arriving this cycle merged over the bytes already captured.
    always_comb begin
        rd_merged = rd_buf;
        if (rd_pend) rd_merged[{rd_idx, 3'b000} +: 8] = mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Strobes decode straight from the state register, so reset drops them at once.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        state_nxt = state;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (take_cpu || take_dbg) state_nxt = sel_misaligned ? DONE : BEAT;
            end
            BEAT: begin
                mem_addr = lat_base + ADDR_W'(beat_cnt);
                mem_we   = lat_we;
                mem_re   = !lat_we;
                if (lat_we) mem_wdata = lat_wdata[{beat_cnt, 3'b000} +: 8];
                if (beat_cnt == last_idx) state_nxt = lat_we ? DONE : RWAIT;
            end
            RWAIT:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign cpu_ack   = (state == DONE) && !grant_dbg;
    assign dbg_ack   = (state == DONE) &&  grant_dbg;
    assign cpu_err   = cpu_ack && lat_err;
    assign dbg_err   = dbg_ack && lat_err;
    assign cpu_stall = cpu_req && !cpu_ack;

    // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_dbg <= 1'b0;
            prio_dbg  <= 1'b0;
            lat_we    <= 1'b0;
            lat_size  <= '0;
            lat_base  <= '0;
            lat_wdata <= '0;
            lat_err   <= 1'b0;
            beat_cnt  <= '0;
            rd_pend   <= 1'b0;
            rd_idx    <= '0;
            rd_buf    <= '0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            rd_pend <= (state == BEAT) && !lat_we;
            rd_idx  <= beat_cnt;
            if (rd_pend) rd_buf <= rd_merged;
            case (state)
                IDLE: begin
                    if (take_cpu || take_dbg) begin
                        grant_dbg <= take_dbg;
                        prio_dbg  <= take_cpu;
                        lat_we    <= sel_we;
                        lat_size  <= sel_size;
                        lat_base  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        lat_err   <= sel_misaligned;
                        beat_cnt  <= '0;
                        rd_buf    <= '0;
                        if (sel_misaligned) begin
                            if (take_dbg) dbg_rdata <= '0;
                            else          cpu_rdata <= '0;
                        end
                    end
                end
                BEAT: beat_cnt <= beat_cnt + 3'd1;
                RWAIT: begin
                    if (grant_dbg) dbg_rdata <= rd_merged;
                    else           cpu_rdata <= rd_merged;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dmem_seq_ctrl.md
DMEM_SEQ_CTRL -- requirements
Module: dmem_seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 13, byte-address width of the data memory (8192 bytes).
REQ-002 Port clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Ports cpu_req/cpu_we  input  1 each  MEM-stage request level / 1=store, 0=load.
REQ-005 Ports cpu_size  input  2  0=byte, 1=half, 2=word, 3=doubleword; cpu_addr  input  64  byte address (bits above ADDR_W-1 ignored); cpu_wdata  input  64.
REQ-006 Ports cpu_rdata  output  64, cpu_ack  output  1, cpu_err  output  1, cpu_stall  output  1 (pipeline hold).
REQ-007 Ports dbg_req, dbg_we  input  1; dbg_size  input  2; dbg_addr  input  ADDR_W; dbg_wdata  input  64; dbg_rdata  output  64; dbg_ack, dbg_err  output  1: debug/loader port, same semantics as cpu_*.
REQ-008 Ports mem_addr  output  ADDR_W, mem_re  output  1, mem_we  output  1, mem_wdata  output  8, mem_rdata  input  8: single-port byte-wide memory, synchronous read (data valid one cycle after mem_re).
REQ-009 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-010 FSM states IDLE, BEAT, RWAIT, DONE; shall use no other states.
REQ-011 In IDLE, a requester whose req is high at a rising edge shall be accepted; its we, size, addr, wdata shall be latched, and later changes to them ignored until its ack.
REQ-012 Both req high in IDLE: grant the port not granted last (round-robin); after reset the CPU wins first.
REQ-013 Beat count N = 1 << size; beat i (0..N-1) uses address (base + i) mod 2^ADDR_W, little-endian (beat i = byte i of data).
REQ-014 BEAT: one beat per cycle, N cycles; mem_we=1 with mem_wdata=byte i for stores, mem_re=1 for loads; strobes shall be 0 in all other states.
REQ-015 Loads: byte from beat i captured the cycle after issue; after the last beat, go to RWAIT for one cycle, then DONE; stores go from last beat directly to DONE.
REQ-016 DONE lasts one cycle; the granted port's ack is high exactly in DONE, then IDLE.
REQ-017 Latency from accepting edge to ack-high cycle: stores N+1 cycles, loads N+2 cycles.
REQ-018 Load data shall be zero-extended to 64 bits; rdata valid in DONE and held until that port's next ack; store acks leave rdata unchanged.
REQ-019 cpu_stall = cpu_req AND NOT cpu_ack (combinational), so the MEM stage holds until completion.
REQ-020 req still high in IDLE after ack is a new request; no back-to-back accept in DONE.
REQ-021 err shall be 0 except as set by REQ-026.

Reset
REQ-022 rst_n low shall immediately force IDLE, mem_re=mem_we=0, mem_addr=0, mem_wdata=0, all ack/err=0, cpu_rdata=dbg_rdata=0, busy=0, round-robin pointer to CPU-next.
REQ-023 Reset mid-transaction shall abandon it without ack; bytes already written remain written.

Configuration
REQ-024 Macro DMEM_ALIGN_CHECK_EN selects alignment checking.
REQ-025 Without the macro: any address accepted; multi-byte accesses wrap per REQ-013.
REQ-026 With the macro: an access with addr mod N != 0 shall produce no memory strobes, go IDLE->DONE in one cycle, assert ack with err=1 and rdata=0; aligned accesses behave as without the macro.

Verification
REQ-027 Reset, then CPU store size=3 addr=0x10 data=0x1122334455667788 -> 8 mem_we beats addr 0x10..0x17, bytes 0x88..0x11, cpu_ack 9 cycles after accept.
REQ-028 CPU load size=3 addr=0x10 -> cpu_rdata=0x1122334455667788, cpu_ack 10 cycles after accept, cpu_stall high until then.
REQ-029 Debug load size=0 addr=0x13 -> dbg_rdata=0x0000000000000055, dbg_ack 3 cycles after accept.
REQ-030 cpu_req and dbg_req raised same edge, twice in succession -> CPU served first, debug second, then CPU again.
REQ-031 Store size=2 addr=0x1FFE, macro off -> writes 0x1FFE,0x1FFF,0x0000,0x0001; macro on -> no strobes, ack with err=1 next cycle.
REQ-032 rst_n low during beat 3 of an 8-beat store -> strobes drop immediately, no ack, bytes 0..2 written, next request served normally.
